// File: rtl/moller_stream_pkg.sv
// moller_stream_pkg: header field positions, parser states and header layout for ti_stream packets
package moller_stream_pkg;
    localparam int ID_MSB  = 63;
    localparam int ID_LSB  = 56;
    localparam int LEN_MSB = 15;
    localparam int LEN_LSB = 0;

    typedef enum logic [1:0] {HDR, PAY, DROP} parser_state_t;

    typedef struct packed {
        logic [7:0]  id;
        logic [39:0] rsvd;
        logic [15:0] len;
    } stream_hdr_t;
endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: 2-entry stream buffer with registered ready, one-cycle latency, full throughput
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_ready upstream; out_data/out_valid/out_ready downstream.
module axis_skid_buffer #(
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    logic [1:0]       count_q, count_d, n;
    logic [WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
    logic             push, pop;

    // ready comes straight from the occupancy register, never from out_ready
    assign in_ready  = ~count_q[1];
    assign out_valid = |count_q;
    assign out_data  = d0_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // d0 is always the head; a pop shifts d1 down, then a push fills the first free slot
    always_comb begin
        n       = count_q - {1'b0, pop};
        d0_d    = pop ? d1_q : d0_q;
        d1_d    = d1_q;
        d0_d    = (push && n == 2'd0) ? in_data : d0_d;
        d1_d    = (push && n == 2'd1) ? in_data : d1_d;
        count_d = n + {1'b0, push};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            d0_q    <= '0;
            d1_q    <= '0;
        end else begin
            count_q <= count_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
        end
    end
endmodule

// File: rtl/axi_stream_len_parser.sv
// axi_stream_len_parser: strips the length/ID header from 64-bit packets and re-emits the payload with regenerated tlast
// Ports: clk, rst (sync, active-high); ena gates new headers; in_* / out_* AXI-Stream; out_len current packet length;
//        err_* one-cycle error pulses; pkt_count/err_count saturating statistics.
// Build option: define AXIS_LEN_PARSER_STATS_EN to implement pkt_count/err_count; otherwise both read 0.
module axi_stream_len_parser
    import moller_stream_pkg::*;
#(
    parameter logic [7:0]  ID          = 8'hF0,
    parameter int unsigned MAX_PKT_LEN = 64,
    parameter bit          CHECK_ID    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [63:0] in_tdata,
    input  logic        in_tvalid,
    input  logic        in_tlast,
    output logic        in_tready,
    output logic [63:0] out_tdata,
    output logic        out_tvalid,
    output logic        out_tlast,
    input  logic        out_tready,
    output logic [15:0] out_len,
    output logic        err_id,
    output logic        err_len_bad,
    output logic        err_short,
    output logic        err_long,
    output logic [31:0] pkt_count,
    output logic [15:0] err_count
);
    parser_state_t state_q, state_d;
    logic [15:0]   cnt_q, cnt_d, len_q, len_d, hdr_len;
    logic [7:0]    hdr_id;
    logic          err_id_q, err_id_d, err_len_bad_q, err_len_bad_d;
    logic          err_short_q, err_short_d, err_long_q, err_long_d;
    logic          skid_ready, in_hs, last_beat, push;
    logic [64:0]   skid_out;

    assign hdr_id    = in_tdata[ID_MSB:ID_LSB];
    assign hdr_len   = in_tdata[LEN_MSB:LEN_LSB];
    assign in_tready = state_q == HDR ? ena : state_q == PAY ? skid_ready : 1'b1;
    assign in_hs     = in_tvalid & in_tready;
    assign last_beat = cnt_q == len_q - 16'd1;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        len_d         = len_q;
        push          = 1'b0;
        err_id_d      = 1'b0;
        err_len_bad_d = 1'b0;
        err_short_d   = 1'b0;
        err_long_d    = 1'b0;
        case (state_q)
            HDR: if (in_hs) begin
                len_d = hdr_len;
                cnt_d = '0;
                // a rejected header that is itself the last beat has nothing left to drop
                if (CHECK_ID && hdr_id != ID) begin
                    err_id_d = 1'b1;
                    state_d  = in_tlast ? HDR : DROP;
                end else if (hdr_len == 16'd0 || hdr_len > 16'(MAX_PKT_LEN)) begin
                    err_len_bad_d = 1'b1;
                    state_d       = in_tlast ? HDR : DROP;
                end else if (in_tlast) begin
                    err_short_d = 1'b1;
                end else begin
                    state_d = PAY;
                end
            end
            PAY: if (in_hs) begin
                push  = 1'b1;
                cnt_d = cnt_q + 16'd1;
                if (last_beat) begin
                    err_long_d = ~in_tlast;
                    state_d    = in_tlast ? HDR : DROP;
                end else if (in_tlast) begin
                    err_short_d = 1'b1;
                    state_d     = HDR;
                end
            end
            default: if (in_hs && in_tlast) state_d = HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HDR;
            cnt_q         <= '0;
            len_q         <= '0;
            err_id_q      <= 1'b0;
            err_len_bad_q <= 1'b0;
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            len_q         <= len_d;
            err_id_q      <= err_id_d;
            err_len_bad_q <= err_len_bad_d;
            err_short_q   <= err_short_d;
            err_long_q    <= err_long_d;
        end
    end

    // tlast is forced on the declared last word so a long packet still closes cleanly downstream
    axis_skid_buffer #(.WIDTH(65)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   ({in_tlast | last_beat, in_tdata}),
        .in_valid  (push),
        .in_ready  (skid_ready),
        .out_data  (skid_out),
        .out_valid (out_tvalid),
        .out_ready (out_tready)
    );

    assign out_tdata   = skid_out[63:0];
    assign out_tlast   = out_tvalid & skid_out[64];
    assign out_len     = len_q;
    assign err_id      = err_id_q;
    assign err_len_bad = err_len_bad_q;
    assign err_short   = err_short_q;
    assign err_long    = err_long_q;

`ifdef AXIS_LEN_PARSER_STATS_EN
    logic [31:0] pkt_count_q, pkt_count_d;
    logic [15:0] err_count_q, err_count_d;
    logic        good, err_any;

    assign good    = state_q == PAY && in_hs && in_tlast && last_beat;
    assign err_any = err_id_d | err_len_bad_d | err_short_d | err_long_d;

    always_comb begin
        pkt_count_d = (good && ~&pkt_count_q) ? pkt_count_q + 32'd1 : pkt_count_q;
        err_count_d = (err_any && ~&err_count_q) ? err_count_q + 16'd1 : err_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count_q <= '0;
            err_count_q <= '0;
        end else begin
            pkt_count_q <= pkt_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign pkt_count = pkt_count_q;
    assign err_count = err_count_q;
`else
    assign pkt_count = '0;
    assign err_count = '0;
`endif
endmodule
